// File: rtl/auto_play_sequencer.sv
// Melody sequencer: walks a song ROM of (index, beats) entries and drives the tone table index.
// Optional build macro AUTOPLAY_LOOP_EN: restart from entry 0 at end of song instead of idling.
module auto_play_sequencer #(
  parameter  int BEAT_CYCLES = 12500000,
  parameter  int GAP_CYCLES  = 1250000,
  parameter  int SONG_LEN    = 32,
  localparam int AW = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1,
  localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1,
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pause,
  input  logic          stop,
  input  logic [4:0]    manualKey,
  output logic [AW-1:0] songAddr,
  input  logic [7:0]    songData,
  output logic [4:0]    autoPlayIndex,
  output logic          playing,
  output logic          done
);

  // state  | meaning
  // IDLE   | waiting for start
  // FETCH  | address presented, ROM read in flight
  // LOAD   | ROM word sampled: end of song or latch note
  // NOTE   | latched index sounding for beats_left beats
  // GAP    | silent gap after a note
  // PAUSED | everything frozen, resume target held in saved_state
  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, NOTE, GAP, PAUSED
  } state_t;

  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(SONG_LEN - 1);

  state_t        state, state_nxt;
  state_t        saved_state, saved_nxt;
  logic [AW-1:0] addr_nxt;
  logic [4:0]    note_idx, idx_nxt;
  logic [2:0]    beats_left, beats_nxt;
  logic [BW-1:0] beat_cnt, beat_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic [4:0]    index_nxt;
  logic          done_nxt;
  logic          end_song;

  assign playing = (state == FETCH) || (state == LOAD) || (state == NOTE) || (state == GAP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      saved_state   <= IDLE;
      songAddr      <= '0;
      note_idx      <= '0;
      beats_left    <= '0;
      beat_cnt      <= '0;
      gap_cnt       <= '0;
      autoPlayIndex <= '0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      saved_state   <= saved_nxt;
      songAddr      <= addr_nxt;
      note_idx      <= idx_nxt;
      beats_left    <= beats_nxt;
      beat_cnt      <= beat_nxt;
      gap_cnt       <= gap_nxt;
      autoPlayIndex <= index_nxt;
      done          <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    saved_nxt = saved_state;
    addr_nxt  = songAddr;
    idx_nxt   = note_idx;
    beats_nxt = beats_left;
    beat_nxt  = beat_cnt;
    gap_nxt   = gap_cnt;
    done_nxt  = 1'b0;
    end_song  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          addr_nxt  = '0;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = LOAD;
      LOAD: begin
        if (songData[2:0] == 3'd0) begin
          end_song = 1'b1;
        end else begin
          idx_nxt   = songData[7:3];
          beats_nxt = songData[2:0];
          beat_nxt  = '0;
          state_nxt = NOTE;
        end
      end
      NOTE: begin
        // note length is duration x BEAT_CYCLES built from two nested counters
        if (beat_cnt == BEAT_LAST) begin
          beat_nxt  = '0;
          beats_nxt = beats_left - 3'd1;
          if (beats_left == 3'd1) begin
            gap_nxt   = '0;
            state_nxt = GAP;
          end
        end else begin
          beat_nxt = beat_cnt + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_nxt = '0;
          if (songAddr == ADDR_LAST) begin
            end_song = 1'b1;
          end else begin
            addr_nxt  = songAddr + 1'b1;
            state_nxt = FETCH;
          end
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      PAUSED: begin
        if (start) state_nxt = saved_state;
      end
      default: state_nxt = IDLE;
    endcase

    if (end_song) begin
      done_nxt = 1'b1;
`ifdef AUTOPLAY_LOOP_EN
      // an empty entry 0 would loop forever without ever sounding, so stop there
      if (state == LOAD && songAddr == '0) begin
        state_nxt = IDLE;
      end else begin
        addr_nxt  = '0;
        state_nxt = FETCH;
      end
`else
      state_nxt = IDLE;
`endif
    end

    // pausing keeps this cycle's counter progress; resume continues from saved_state
    if (stop) begin
      state_nxt = IDLE;
      addr_nxt  = '0;
      beats_nxt = '0;
      beat_nxt  = '0;
      gap_nxt   = '0;
      done_nxt  = 1'b0;
    end else if (pause && playing && !end_song) begin
      saved_nxt = state_nxt;
      state_nxt = PAUSED;
    end

    if (manualKey != 5'd0)     index_nxt = manualKey;
    else if (state_nxt == NOTE) index_nxt = idx_nxt;
    else                        index_nxt = 5'd0;
  end

endmodule

// File: tb/tb_auto_play_sequencer.sv
// Directed bench for auto_play_sequencer with BEAT_CYCLES=4, GAP_CYCLES=2, SONG_LEN=8.
// Expectations follow the AUTOPLAY_LOOP_EN build macro when it is defined.
module tb_auto_play_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, pause, stop;
  logic [4:0] manualKey;
  logic [2:0] songAddr;
  logic [7:0] songData;
  logic [4:0] autoPlayIndex;
  logic       playing, done;

  logic [7:0] rom [8];
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       st;
    logic [4:0] e_idx;
    logic       e_play;
    logic       e_done;
  } vec_t;
  vec_t tbl [24];

  always #5 clk = ~clk;

  // ROM with one cycle of read latency
  always @(posedge clk) songData <= rom[songAddr];

  auto_play_sequencer #(.BEAT_CYCLES(4), .GAP_CYCLES(2), .SONG_LEN(8)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
    .manualKey(manualKey), .songAddr(songAddr), .songData(songData),
    .autoPlayIndex(autoPlayIndex), .playing(playing), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_short_song();
    for (int k = 0; k < 8; k++) rom[k] = 8'h00;
    rom[0] = 8'h49;
    rom[1] = 8'h52;
  endtask

  task automatic fill(input int first, input int last, input logic [4:0] idx, input logic ply, input logic dn);
    for (int i = first; i <= last; i++) begin
      tbl[i].st = 1'b0; tbl[i].e_idx = idx; tbl[i].e_play = ply; tbl[i].e_done = dn;
    end
  endtask

  initial begin
    int c;
    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; manualKey = 5'd0;
    load_short_song();

    // record i: inputs sampled at edge i, outputs expected during the following cycle
    fill(0, 1, 5'd0, 1'b1, 1'b0);
    tbl[0].st = 1'b1;
    fill(2, 5, 5'd9, 1'b1, 1'b0);
    fill(6, 9, 5'd0, 1'b1, 1'b0);
    fill(10, 17, 5'd10, 1'b1, 1'b0);
    fill(18, 21, 5'd0, 1'b1, 1'b0);
`ifdef AUTOPLAY_LOOP_EN
    fill(22, 22, 5'd0, 1'b1, 1'b1);
    fill(23, 23, 5'd0, 1'b1, 1'b0);
`else
    fill(22, 22, 5'd0, 1'b0, 1'b1);
    fill(23, 23, 5'd0, 1'b0, 1'b0);
`endif

    repeat (2) @(negedge clk);
    chk("rst_idx", autoPlayIndex, 0);
    chk("rst_playing", playing, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", songAddr, 0);
    rst = 1'b0;
    tick();

    // short song, table driven
    for (int i = 0; i < 24; i++) begin
      start = tbl[i].st;
      tick();
      start = 1'b0;
      chk($sformatf("tbl%0d_idx", i), autoPlayIndex, tbl[i].e_idx);
      chk($sformatf("tbl%0d_playing", i), playing, tbl[i].e_play);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
    end
    do_stop();

    // full 8-entry song: done 65 cycles after the start edge
    for (int k = 0; k < 8; k++) rom[k] = {5'(k + 1), 3'd1};
    do_start();
    c = 1;
    while (!done && c < 200) begin
      tick();
      c++;
    end
    chk("full_done_cycle", c, 65);
`ifdef AUTOPLAY_LOOP_EN
    chk("full_loop_playing", playing, 1);
    chk("full_loop_addr", songAddr, 0);
    tick(); tick();
    chk("full_loop_replay_idx", autoPlayIndex, 1);
`else
    chk("full_end_playing", playing, 0);
    tick();
    chk("full_done_once", done, 0);
    chk("full_idle_playing", playing, 0);
`endif
    do_stop();

    // pause on 2nd note cycle, 10 cycles paused, then resume
    load_short_song();
    do_start();
    tick(); tick(); tick();
    chk("pause_pre_idx", autoPlayIndex, 9);
    pause = 1'b1;
    tick();
    pause = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("paused%0d_idx", i), autoPlayIndex, 0);
      chk($sformatf("paused%0d_playing", i), playing, 0);
      if (i < 9) tick();
    end
    chk("paused_addr", songAddr, 0);
    do_start();
    chk("resume1_idx", autoPlayIndex, 9);
    tick();
    chk("resume2_idx", autoPlayIndex, 9);
    tick();
    chk("resume_gap_idx", autoPlayIndex, 0);
    chk("resume_gap_playing", playing, 1);
    do_stop();

    // manual key override during and after the note
    do_start();
    tick(); tick();
    chk("man_note_idx", autoPlayIndex, 9);
    manualKey = 5'b11001;
    tick();
    chk("man_key1", autoPlayIndex, 25);
    tick();
    chk("man_key2", autoPlayIndex, 25);
    manualKey = 5'd0;
    tick();
    chk("man_release_note", autoPlayIndex, 9);
    tick();
    chk("man_gap", autoPlayIndex, 0);
    manualKey = 5'd3;
    tick();
    chk("man_key_gap", autoPlayIndex, 3);
    manualKey = 5'd0;
    tick();
    chk("man_release_silent", autoPlayIndex, 0);
    tick(); tick();
    chk("man_next_note_timing", autoPlayIndex, 10);
    do_stop();

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("startstop_playing", playing, 0);
    tick();
    chk("startstop_playing2", playing, 0);
    chk("startstop_addr", songAddr, 0);

    // stop during the gap after entry 1
    do_start();
    repeat (18) tick();
    chk("stopgap_pre_addr", songAddr, 1);
    chk("stopgap_pre_playing", playing, 1);
    chk("stopgap_pre_idx", autoPlayIndex, 0);
    do_stop();
    chk("stopgap_playing", playing, 0);
    chk("stopgap_addr", songAddr, 0);
    chk("stopgap_done", done, 0);
    tick();
    chk("stopgap_done2", done, 0);

    // async reset in the middle of entry 1
    do_start();
    repeat (11) tick();
    chk("rstmid_pre_idx", autoPlayIndex, 10);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_idx", autoPlayIndex, 0);
    chk("rstmid_playing", playing, 0);
    chk("rstmid_addr", songAddr, 0);
    chk("rstmid_done", done, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    do_start();
    chk("rstmid_fetch_addr", songAddr, 0);
    tick(); tick();
    chk("rstmid_replay_idx", autoPlayIndex, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/auto_play_sequencer.md
# auto_play_sequencer

Melody controller in front of the tone lookup table. Walks a song ROM of (note index, duration) entries, holds each note's 5-bit index for its programmed number of beats, inserts a rest gap between notes, and drives the table's `autoPlayIndex` input. Supports start/pause/stop and gives the live keypad priority over playback.

## Interface
- `BEAT_CYCLES`, default 12500000: clock cycles per duration unit. Must be ≥ 1.
- `GAP_CYCLES`, default 1250000: silent cycles after each note. Must be ≥ 1.
- `SONG_LEN`, default 32: number of ROM entries. Power of 2, ≤ 32.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse: begin from entry 0 (in IDLE) or resume (in PAUSED).
- `pause`  in  1  one-cycle pulse: freeze playback.
- `stop`  in  1  one-cycle pulse: abort to IDLE.
- `manualKey`  in  5  live keypad index. 0 means no key pressed.
- `songAddr`  out  log2(SONG_LEN)  ROM address.
- `songData`  in  8  ROM word. `[7:3]` is the note index; `[2:0]` is the duration in beats. Duration 0 marks end of song.
- `autoPlayIndex`  out  5  registered index to the tone table. 0 means silence.
- `playing`  out  1  high in FETCH, LOAD, NOTE and GAP.
- `done`  out  1  one-cycle pulse at end of song.

## Operation
- States: IDLE, FETCH, LOAD, NOTE, GAP, PAUSED.
- IDLE, on `start`: set `songAddr` = 0 and go to FETCH.
- FETCH: `songAddr` is stable. The ROM has one cycle of read latency. Next state is LOAD.
- LOAD: sample `songData`.
  - If duration = 0: go to IDLE and pulse `done`.
  - Otherwise: latch the index, set beats-left = duration and beat counter = 0, then go to NOTE.
- NOTE:
  - The beat counter counts 0..BEAT_CYCLES-1. At the wrap, beats-left decrements.
  - When the last beat wraps, go to GAP with the gap counter = 0.
  - Note length is exactly duration×BEAT_CYCLES cycles. No multiplier is used.
- GAP: lasts GAP_CYCLES cycles, then:
  - If `songAddr` = SONG_LEN-1: end of song. Go to IDLE and pulse `done`.
  - Otherwise: `songAddr` += 1 and go to FETCH.
- `pause` in FETCH, LOAD, NOTE or GAP: go to PAUSED.
  - All counters, `songAddr` and the latched index freeze.
  - `start` returns to the saved state. The remaining counts continue unchanged.
  - `pause` is ignored in IDLE and PAUSED.
- `stop` in any state: go to IDLE and clear all counters. `songAddr` = 0. No `done` pulse.
- Simultaneous pulses: `stop` beats `pause`, and `pause` beats `start`. `start` while playing is ignored.
- Output mux, registered:
  - `manualKey` ≠ 0: `autoPlayIndex` = `manualKey`. The sequencer keeps running silently underneath.
  - Else in NOTE: the latched index.
  - Else: 0.
- Indices are passed through unchecked. Codes the table does not map play as silence.

## Timing
- Reset values: state IDLE, `songAddr` 0, `autoPlayIndex` 0, `playing` 0, `done` 0, all counters 0.
- `start` sampled at edge n: FETCH during cycle n+1, LOAD during n+2, first note on `autoPlayIndex` from cycle n+3.
- Silence between consecutive notes is GAP_CYCLES+2 cycles (GAP, then FETCH, then LOAD).
- `manualKey` reaches `autoPlayIndex` one cycle after it is sampled.
- `done` is high for exactly the cycle after the terminating LOAD or GAP edge, coincident with `playing` going low.
- `rst` asserted mid-note: outputs clear immediately (asynchronously).

## Configuration
- `AUTOPLAY_LOOP_EN` defined:
  - At end of song (duration-0 entry, or GAP finishing at SONG_LEN-1), `done` still pulses.
  - `songAddr` wraps to 0 and the state goes to FETCH instead of IDLE. `playing` stays high.
  - If entry 0 itself has duration 0, go to IDLE anyway. This prevents a livelock.
- `AUTOPLAY_LOOP_EN` undefined: end of song returns to IDLE.

## Test plan
Bench parameters for all cases: BEAT_CYCLES=4, GAP_CYCLES=2, SONG_LEN=8.

- ROM {0x49 (idx 9, dur 1), 0x52 (idx 10, dur 2), 0x00}. `start` at cycle 0.
  - Required: idx 9 on cycles 3–6; 0 on cycles 7–10; idx 10 on cycles 11–18.
  - Then `done` at the LOAD of entry 2, and `playing` = 0.
- All 8 entries nonzero.
  - Required: after the GAP of entry 7, `done` pulses and the state is IDLE.
  - With `AUTOPLAY_LOOP_EN`: `songAddr` returns to 0 and entry 0 replays.
- `pause` on the 2nd cycle of a 4-cycle note, hold 10 cycles, then `start`.
  - Required: output 0 while paused; exactly 2 note cycles remain after resume.
- `manualKey` = 5'b11001 during NOTE of idx 9.
  - Required: `autoPlayIndex` = 25 one cycle later.
  - On release, the output returns to 9 if the note is still running, otherwise 0. The note timing is unchanged.
- `start`+`stop` together in IDLE: no FETCH occurs.
- `stop` mid-GAP: IDLE with `songAddr` = 0 and no `done`.
- `rst` asserted mid-note: all outputs 0 asynchronously. After release, `start` plays from entry 0.
